// File: rtl/rule_access_ctrl_if.sv
// rtl/rule_access_ctrl_if.sv - host register bus and TCAM rule port bundle
interface rule_access_ctrl_if #(
  parameter int TUPLE_WIDTH        = 104,
  parameter int MON_LUT_DEPTH_BITS = 5,
  parameter int REG_ADDR_WIDTH     = 4
);
  logic                          reg_req;
  logic                          reg_rnw;
  logic [REG_ADDR_WIDTH-1:0]     reg_addr;
  logic [31:0]                   reg_wr_data;
  logic                          reg_ack;
  logic [31:0]                   reg_rd_data;

  logic                          rule_wr_req;
  logic [MON_LUT_DEPTH_BITS-1:0] rule_wr_addr;
  logic [TUPLE_WIDTH-1:0]        rule_wr;
  logic [TUPLE_WIDTH-1:0]        rule_wr_mask;
  logic                          rule_wr_ack;
  logic [MON_LUT_DEPTH_BITS-1:0] rule_rd_addr;
  logic                          rule_rd_req;
  logic [TUPLE_WIDTH-1:0]        rule_rd;
  logic [TUPLE_WIDTH-1:0]        rule_rd_mask;
  logic                          rule_rd_ack;

  modport master (
    output reg_req, reg_rnw, reg_addr, reg_wr_data,
    input  reg_ack, reg_rd_data,
    input  rule_wr_req, rule_wr_addr, rule_wr, rule_wr_mask, rule_rd_addr, rule_rd_req,
    output rule_wr_ack, rule_rd, rule_rd_mask, rule_rd_ack
  );

  modport slave (
    input  reg_req, reg_rnw, reg_addr, reg_wr_data,
    output reg_ack, reg_rd_data,
    output rule_wr_req, rule_wr_addr, rule_wr, rule_wr_mask, rule_rd_addr, rule_rd_req,
    input  rule_wr_ack, rule_rd, rule_rd_mask, rule_rd_ack
  );
endinterface

// File: rtl/rule_access_ctrl.sv
// rtl/rule_access_ctrl.sv - register-staged TCAM rule write/read initiator with ack timeout
module rule_access_ctrl #(
  parameter int TUPLE_WIDTH        = 104,
  parameter int MON_LUT_DEPTH_BITS = 5,
  parameter int TIMEOUT_CYCLES     = 64,
  parameter int REG_ADDR_WIDTH     = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  rule_access_ctrl_if.slave  io_bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT} state_t;

  state_t                        r_state, w_next_state;
  logic [TUPLE_WIDTH-1:0]        r_tuple, r_mask;
  logic [MON_LUT_DEPTH_BITS-1:0] r_addr;
  logic [CW-1:0]                 r_to_cnt;
  logic [15:0]                   r_count;
  logic                          r_done, r_timeout, r_cmd_err;
  logic                          r_reg_ack, r_rd_req;
  logic [31:0]                   r_reg_rd_data, w_rd_mux;
  logic                          w_busy, w_wr_req;
  logic                          w_host_wr, w_low_addr, w_wr_ok, w_cmd;
  logic                          w_start_wr, w_start_rd, w_bad_cmd;
  logic                          w_wr_ack_hit, w_rd_ack_hit, w_to_hit;
  logic                          w_set_done, w_set_err, w_stat_rd;

  assign w_host_wr    = io_bus.reg_req & ~io_bus.reg_rnw;
  assign w_low_addr   = int'(io_bus.reg_addr) <= 9;
  assign w_wr_ok      = w_host_wr & ~(w_busy & w_low_addr);
  assign w_cmd        = w_wr_ok & (int'(io_bus.reg_addr) == 9);
  assign w_start_wr   = w_cmd & (io_bus.reg_wr_data[1:0] == 2'b01);
  assign w_start_rd   = w_cmd & (io_bus.reg_wr_data[1:0] == 2'b10);
  assign w_bad_cmd    = w_cmd & (io_bus.reg_wr_data[1:0] == 2'b11);
  assign w_wr_ack_hit = (r_state == S_WR_WAIT) & io_bus.rule_wr_ack;
  assign w_rd_ack_hit = (r_state == S_RD_WAIT) & io_bus.rule_rd_ack;
  // An ack arriving on the last wait cycle still counts as success.
  assign w_to_hit     = (((r_state == S_WR_WAIT) & ~io_bus.rule_wr_ack) |
                         ((r_state == S_RD_WAIT) & ~io_bus.rule_rd_ack)) &
                        (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_set_done   = w_wr_ack_hit | w_rd_ack_hit;
  assign w_set_err    = (w_host_wr & w_busy & w_low_addr) | w_bad_cmd;
  assign w_stat_rd    = io_bus.reg_req & io_bus.reg_rnw & (int'(io_bus.reg_addr) == 10);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_wr)      w_next_state = S_WR_WAIT;
        else if (w_start_rd) w_next_state = S_RD_ISSUE;
      end
      S_WR_WAIT:  if (w_wr_ack_hit | w_to_hit) w_next_state = S_IDLE;
      S_RD_ISSUE: w_next_state = S_RD_WAIT;
      S_RD_WAIT:  if (w_rd_ack_hit | w_to_hit) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_wr_req = (r_state == S_WR_WAIT) & ~io_bus.rule_wr_ack;
  end

  always_comb begin
    w_rd_mux = '0;
    case (int'(io_bus.reg_addr))
      0:  w_rd_mux = r_tuple[31:0];
      1:  w_rd_mux = r_tuple[63:32];
      2:  w_rd_mux = r_tuple[95:64];
      3:  w_rd_mux = 32'(r_tuple[TUPLE_WIDTH-1:96]);
      4:  w_rd_mux = r_mask[31:0];
      5:  w_rd_mux = r_mask[63:32];
      6:  w_rd_mux = r_mask[95:64];
      7:  w_rd_mux = 32'(r_mask[TUPLE_WIDTH-1:96]);
      8:  w_rd_mux = 32'(r_addr);
      10: w_rd_mux = {28'd0, r_cmd_err, r_timeout, r_done, w_busy};
      11: w_rd_mux = {16'd0, r_count};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tuple       <= '0;
      r_mask        <= '0;
      r_addr        <= '0;
      r_to_cnt      <= '0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_reg_ack     <= 1'b0;
      r_reg_rd_data <= '0;
      r_rd_req      <= 1'b0;
    end else begin
      r_reg_ack     <= io_bus.reg_req;
      r_reg_rd_data <= (io_bus.reg_req & io_bus.reg_rnw) ? w_rd_mux : 32'd0;
      r_rd_req      <= (w_next_state == S_RD_ISSUE);
      r_to_cnt      <= ((r_state == S_WR_WAIT) | (r_state == S_RD_WAIT)) ? r_to_cnt + CW'(1) : '0;
      if (w_wr_ok) begin
        case (int'(io_bus.reg_addr))
          0:  r_tuple[31:0]              <= io_bus.reg_wr_data;
          1:  r_tuple[63:32]             <= io_bus.reg_wr_data;
          2:  r_tuple[95:64]             <= io_bus.reg_wr_data;
          3:  r_tuple[TUPLE_WIDTH-1:96]  <= io_bus.reg_wr_data[TUPLE_WIDTH-97:0];
          4:  r_mask[31:0]               <= io_bus.reg_wr_data;
          5:  r_mask[63:32]              <= io_bus.reg_wr_data;
          6:  r_mask[95:64]              <= io_bus.reg_wr_data;
          7:  r_mask[TUPLE_WIDTH-1:96]   <= io_bus.reg_wr_data[TUPLE_WIDTH-97:0];
          8:  r_addr                     <= io_bus.reg_wr_data[MON_LUT_DEPTH_BITS-1:0];
          11: r_count                    <= io_bus.reg_wr_data[15:0];
          default: ;
        endcase
      end
      if (w_rd_ack_hit) begin
        r_tuple <= io_bus.rule_rd;
        r_mask  <= io_bus.rule_rd_mask;
      end
      if (w_set_done) r_count <= r_count + 16'd1;
      r_done    <= w_set_done | (r_done    & ~w_stat_rd);
      r_timeout <= w_to_hit   | (r_timeout & ~w_stat_rd);
      r_cmd_err <= w_set_err  | (r_cmd_err & ~w_stat_rd);
    end
  end

  assign io_bus.reg_ack      = r_reg_ack;
  assign io_bus.reg_rd_data  = r_reg_rd_data;
  assign io_bus.rule_wr_req  = w_wr_req;
  assign io_bus.rule_wr_addr = r_addr;
  assign io_bus.rule_wr      = r_tuple;
  assign io_bus.rule_wr_mask = r_mask;
  assign io_bus.rule_rd_addr = r_addr;
  assign io_bus.rule_rd_req  = r_rd_req;
endmodule

// File: tb/tb_rule_access_ctrl.sv
// tb/tb_rule_access_ctrl.sv - randomized self-checking bench for rule_access_ctrl
module tb_rule_access_ctrl;
  localparam int TW = 104;
  localparam int DB = 5;
  localparam int TO = 64;
  localparam int RA = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rule_access_ctrl_if #(.TUPLE_WIDTH(TW), .MON_LUT_DEPTH_BITS(DB), .REG_ADDR_WIDTH(RA)) bus ();

  rule_access_ctrl #(
    .TUPLE_WIDTH(TW), .MON_LUT_DEPTH_BITS(DB), .TIMEOUT_CYCLES(TO), .REG_ADDR_WIDTH(RA)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents as the host sees them.
  logic [31:0] m_rule [4];
  logic [31:0] m_mask [4];
  logic [4:0]  m_addr;
  bit          m_done, m_to, m_err;
  int          m_count;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_rule[i] = '0;
      m_mask[i] = '0;
    end
    m_addr = '0; m_done = 0; m_to = 0; m_err = 0; m_count = 0;
  endfunction

  function automatic logic [TW-1:0] model_tuple();
    return {m_rule[3][7:0], m_rule[2], m_rule[1], m_rule[0]};
  endfunction

  function automatic logic [TW-1:0] model_mask();
    return {m_mask[3][7:0], m_mask[2], m_mask[1], m_mask[0]};
  endfunction

  function automatic logic [31:0] model_reg(input int a);
    if (a < 4)   return m_rule[a];
    if (a < 8)   return m_mask[a-4];
    if (a == 8)  return {27'd0, m_addr};
    if (a == 10) return {28'd0, m_err, m_to, m_done, 1'b0};
    if (a == 11) return m_count & 32'hFFFF;
    return 32'd0;
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    if (a < 3)                 m_rule[a] = d;
    else if (a == 3)           m_rule[3] = d & 32'hFF;
    else if (a >= 4 && a < 7)  m_mask[a-4] = d;
    else if (a == 7)           m_mask[3] = d & 32'hFF;
    else if (a == 8)           m_addr = d[4:0];
    else if (a == 11)          m_count = d & 32'hFFFF;
  endfunction

  task automatic reg_write(input int a, input logic [31:0] d);
    bus.reg_req = 1'b1; bus.reg_rnw = 1'b0; bus.reg_addr = RA'(a); bus.reg_wr_data = d;
    @(posedge clk); #1;
    bus.reg_req = 1'b0;
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    reg_write(a, d);
    model_write(a, d);
  endtask

  task automatic reg_read(input int a, output logic [31:0] d);
    bus.reg_req = 1'b1; bus.reg_rnw = 1'b1; bus.reg_addr = RA'(a);
    @(posedge clk); #1;
    bus.reg_req = 1'b0;
    check("reg_ack", bus.reg_ack, 1);
    d = bus.reg_rd_data;
  endtask

  task automatic check_reg(input string tag, input int a);
    logic [31:0] d;
    reg_read(a, d);
    check(tag, d, model_reg(a));
    if (a == 10) begin m_done = 0; m_to = 0; m_err = 0; end
  endtask

  task automatic run_write(input int ack_cycle, input string tag);
    int hi;
    hi = 0;
    reg_write(9, 1);
    check({tag, "_wr_addr"}, bus.rule_wr_addr, m_addr);
    check({tag, "_wr_tuple"}, bus.rule_wr, model_tuple());
    check({tag, "_wr_mask"}, bus.rule_wr_mask, model_mask());
    for (int c = 0; c < TO + 4; c++) begin
      if (bus.rule_wr_req) hi++;
      if (c == ack_cycle) begin
        bus.rule_wr_ack = 1'b1;
        #1 check({tag, "_req_in_ack"}, bus.rule_wr_req, 0);
        @(posedge clk); #1;
        bus.rule_wr_ack = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_req_cycles"}, hi, (ack_cycle < TO) ? ack_cycle + 1 : TO);
    check({tag, "_req_idle"}, bus.rule_wr_req, 0);
    if (ack_cycle < TO) begin m_done = 1; m_count = (m_count + 1) & 32'hFFFF; end
    else m_to = 1;
  endtask

  task automatic run_read(input int ack_cycle, input logic [TW-1:0] rd, input logic [TW-1:0] rm,
                          input string tag);
    int hi;
    reg_write(9, 2);
    check({tag, "_rd_addr"}, bus.rule_rd_addr, m_addr);
    hi = int'(bus.rule_rd_req);
    @(posedge clk); #1;
    for (int c = 0; c < TO + 4; c++) begin
      if (bus.rule_rd_req) hi++;
      if (c == ack_cycle) begin
        bus.rule_rd_ack = 1'b1; bus.rule_rd = rd; bus.rule_rd_mask = rm;
        @(posedge clk); #1;
        bus.rule_rd_ack = 1'b0; bus.rule_rd = '0; bus.rule_rd_mask = '0;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_rd_pulse"}, hi, 1);
    if (ack_cycle < TO) begin
      m_rule[0] = rd[31:0]; m_rule[1] = rd[63:32]; m_rule[2] = rd[95:64]; m_rule[3] = 32'(rd[103:96]);
      m_mask[0] = rm[31:0]; m_mask[1] = rm[63:32]; m_mask[2] = rm[95:64]; m_mask[3] = 32'(rm[103:96]);
      m_done = 1; m_count = (m_count + 1) & 32'hFFFF;
    end else m_to = 1;
  endtask

  function automatic logic [TW-1:0] rand_tuple();
    return {8'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bus.reg_req = 0; bus.reg_rnw = 0; bus.reg_addr = '0; bus.reg_wr_data = '0;
    bus.rule_wr_ack = 0; bus.rule_rd_ack = 0; bus.rule_rd = '0; bus.rule_rd_mask = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_req", bus.rule_wr_req, 0);
    check("rst_rd_req", bus.rule_rd_req, 0);
    check("rst_reg_ack", bus.reg_ack, 0);
    rst = 1'b0;

    // Reset in the middle of a write wait
    host_write(0, 32'hA5A5A5A5);
    host_write(8, 3);
    reg_write(9, 1);
    @(posedge clk); #1;
    check("mid_req_high", bus.rule_wr_req, 1);
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_req", bus.rule_wr_req, 0);
    check("mid_rst_tuple", bus.rule_wr, model_tuple());
    @(posedge clk); #1;
    rst = 1'b0;
    check_reg("rst_status", 10);
    check_reg("rst_count", 11);
    check_reg("rst_w0", 0);

    // Directed write
    host_write(0, 32'h11111111);
    check("wr_ack", bus.reg_ack, 1);
    check("wr_ack_rd0", bus.reg_rd_data, 0);
    host_write(1, 32'h22222222);
    host_write(2, 32'h33333333);
    host_write(3, 32'h000000AB);
    for (int i = 4; i < 7; i++) host_write(i, 32'hFFFFFFFF);
    host_write(7, 32'h000000FF);
    host_write(8, 5);
    check("t2_tuple_const", bus.rule_wr, 104'hAB_33333333_22222222_11111111);
    run_write(3, "t2");
    check_reg("t2_status", 10);
    check_reg("t2_count", 11);
    check_reg("t2_status_clr", 10);

    // Directed read
    host_write(8, 7);
    run_read(1, 104'h5A_DEADBEEF_CAFEF00D_12345678, rand_tuple(), "t3");
    check_reg("t3_w0", 0);
    check_reg("t3_w3", 3);
    check_reg("t3_m0", 4);
    check_reg("t3_status", 10);

    // Timeout
    run_write(1000, "t4");
    check_reg("t4_status", 10);
    check_reg("t4_status_clr", 10);
    check_reg("t4_count", 11);

    // Host writes while busy are dropped
    reg_write(9, 1);
    reg_write(0, 32'h0BADF00D);
    reg_write(9, 2);
    m_err = 1;
    check("t5_tuple_stable", bus.rule_wr, model_tuple());
    check("t5_no_rd_req", bus.rule_rd_req, 0);
    bus.rule_wr_ack = 1'b1;
    #1 check("t5_req_drop", bus.rule_wr_req, 0);
    @(posedge clk); #1;
    bus.rule_wr_ack = 1'b0;
    m_done = 1; m_count = (m_count + 1) & 32'hFFFF;
    check_reg("t5_status", 10);
    check_reg("t5_w0", 0);

    reg_write(9, 3);
    m_err = 1;
    check("t5_bad_wr_req", bus.rule_wr_req, 0);
    check("t5_bad_rd_req", bus.rule_rd_req, 0);
    check_reg("t5_bad_status", 10);
    reg_write(9, 0);
    check("t5_nop_req", bus.rule_wr_req, 0);
    check_reg("t5_nop_status", 10);

    run_write(TO - 1, "t5_late");
    check_reg("t5_late_status", 10);

    // STATUS read in the same cycle done is set: busy shows, done survives
    reg_write(9, 1);
    bus.rule_wr_ack = 1'b1;
    bus.reg_req = 1'b1; bus.reg_rnw = 1'b1; bus.reg_addr = RA'(10);
    @(posedge clk); #1;
    bus.rule_wr_ack = 1'b0; bus.reg_req = 1'b0;
    check("t5_race_rd", bus.reg_rd_data, 32'd1);
    m_done = 1; m_count = (m_count + 1) & 32'hFFFF;
    check_reg("t5_race_status", 10);

    // Count wrap and stray acks
    host_write(11, 32'h0000FFFF);
    run_write(0, "t6");
    check_reg("t6_count_wrap", 11);
    check_reg("t6_status", 10);
    bus.rule_rd_ack = 1'b1; bus.rule_rd = rand_tuple(); bus.rule_wr_ack = 1'b1;
    @(posedge clk); #1;
    bus.rule_rd_ack = 1'b0; bus.rule_rd = '0; bus.rule_wr_ack = 1'b0;
    check_reg("t6_stray_status", 10);
    check_reg("t6_stray_w0", 0);
    check_reg("t6_stray_count", 11);

    // Randomized mix
    for (int it = 0; it < 30; it++) begin
      int op;
      for (int k = 0; k < 3; k++) begin
        int a;
        a = $urandom_range(0, 15);
        if (a == 9) a = 8;
        host_write(a, $urandom);
      end
      op = $urandom_range(0, 2);
      if (op == 0) run_write($urandom_range(0, 70), "rnd");
      else if (op == 1) run_read($urandom_range(0, 70), rand_tuple(), rand_tuple(), "rnd");
      check_reg("rnd_status", 10);
      check_reg("rnd_count", 11);
      check_reg("rnd_reg", $urandom_range(0, 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
